// File: rtl/morse_keyer_if.sv
// Character channel into the Morse keyer.
//
// Handshake: a character moves on a rising clk edge where charValid and
// charReady are both 1. The source keeps charData stable while charValid is
// high and not yet accepted. The keyer samples charData on that edge. It
// ignores the input afterwards until it raises charReady again.
interface morse_keyer_if;
    logic [7:0] charData;
    logic       charValid;
    logic       charReady;

    modport master (
        output charData,
        output charValid,
        input  charReady
    );

    modport slave (
        input  charData,
        input  charValid,
        output charReady
    );
endinterface

// File: rtl/morse_keyer.sv
// Character-to-Morse keying sequencer.
// The keyer accepts one ASCII byte while IDLE and plays it on key as marks and
// gaps with standard Morse proportions. One dot unit lasts unitCycles clocks.
// A space plays the extra four units that turn a character gap into a word gap.
// Bytes it cannot send are swallowed, and it produces no key activity for them.
module morse_keyer #(
    parameter real    frequency  = 60_000_000.0,
    parameter real    wpm        = 20.0,
    parameter longint unitCycles = longint'(frequency * 1.2 / wpm)
) (
    input  logic         clk,
    input  logic         reset,
    morse_keyer_if.slave char_if,
    output logic         key,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    // Every interval counts down to zero, so the counter loads duration-1.
    // 3x and 4x are formed here in 64 bits and must fit in 32 bits.
    localparam logic [31:0] DOT_M1  = 32'(unitCycles - 1);
    localparam logic [31:0] DASH_M1 = 32'(3 * unitCycles - 1);
    localparam logic [31:0] WORD_M1 = 32'(4 * unitCycles - 1);

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MARK     = 3'd1,
        ELEM_GAP = 3'd2,
        CHAR_GAP = 3'd3,
        WORD_GAP = 3'd4
    } state_t;

    // ok = sendable, len = element count, pat = elements LSB first (1 = dash)
    typedef struct packed {
        logic       ok;
        logic [2:0] len;
        logic [4:0] pat;
    } code_t;

    function automatic code_t morse_lut(input logic [7:0] c);
        logic [7:0] u;
        code_t      r;
        u = c;
        if (c >= 8'h61 && c <= 8'h7A) begin
            u = c - 8'h20;
        end
        case (u)
            8'h41: r = {1'b1, 3'd2, 5'b00010};  // A .-
            8'h42: r = {1'b1, 3'd4, 5'b00001};  // B -...
            8'h43: r = {1'b1, 3'd4, 5'b00101};  // C -.-.
            8'h44: r = {1'b1, 3'd3, 5'b00001};  // D -..
            8'h45: r = {1'b1, 3'd1, 5'b00000};  // E .
            8'h46: r = {1'b1, 3'd4, 5'b00100};  // F ..-.
            8'h47: r = {1'b1, 3'd3, 5'b00011};  // G --.
            8'h48: r = {1'b1, 3'd4, 5'b00000};  // H ....
            8'h49: r = {1'b1, 3'd2, 5'b00000};  // I ..
            8'h4A: r = {1'b1, 3'd4, 5'b01110};  // J .---
            8'h4B: r = {1'b1, 3'd3, 5'b00101};  // K -.-
            8'h4C: r = {1'b1, 3'd4, 5'b00010};  // L .-..
            8'h4D: r = {1'b1, 3'd2, 5'b00011};  // M --
            8'h4E: r = {1'b1, 3'd2, 5'b00001};  // N -.
            8'h4F: r = {1'b1, 3'd3, 5'b00111};  // O ---
            8'h50: r = {1'b1, 3'd4, 5'b00110};  // P .--.
            8'h51: r = {1'b1, 3'd4, 5'b01011};  // Q --.-
            8'h52: r = {1'b1, 3'd3, 5'b00010};  // R .-.
            8'h53: r = {1'b1, 3'd3, 5'b00000};  // S ...
            8'h54: r = {1'b1, 3'd1, 5'b00001};  // T -
            8'h55: r = {1'b1, 3'd3, 5'b00100};  // U ..-
            8'h56: r = {1'b1, 3'd4, 5'b01000};  // V ...-
            8'h57: r = {1'b1, 3'd3, 5'b00110};  // W .--
            8'h58: r = {1'b1, 3'd4, 5'b01001};  // X -..-
            8'h59: r = {1'b1, 3'd4, 5'b01101};  // Y -.--
            8'h5A: r = {1'b1, 3'd4, 5'b00011};  // Z --..
            8'h30: r = {1'b1, 3'd5, 5'b11111};  // 0 -----
            8'h31: r = {1'b1, 3'd5, 5'b11110};  // 1 .----
            8'h32: r = {1'b1, 3'd5, 5'b11100};  // 2 ..---
            8'h33: r = {1'b1, 3'd5, 5'b11000};  // 3 ...--
            8'h34: r = {1'b1, 3'd5, 5'b10000};  // 4 ....-
            8'h35: r = {1'b1, 3'd5, 5'b00000};  // 5 .....
            8'h36: r = {1'b1, 3'd5, 5'b00001};  // 6 -....
            8'h37: r = {1'b1, 3'd5, 5'b00011};  // 7 --...
            8'h38: r = {1'b1, 3'd5, 5'b00111};  // 8 ---..
            8'h39: r = {1'b1, 3'd5, 5'b01111};  // 9 ----.
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  char_q, char_d;
    logic        key_q, key_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic [7:0]  code_src;
    code_t       code;
    logic        take;

    // Next-state and next-output logic for the keying sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        char_d  = char_q;

        // In IDLE the live input is decoded to choose the first interval.
        // After that the held copy drives the LUT.
        code_src = (state_q == IDLE) ? char_if.charData : char_q;
        code     = morse_lut(code_src);
        take     = (state_q == IDLE) && ready_q && char_if.charValid;

        unique case (state_q)
            IDLE: begin
                idx_d = 3'd0;
                cnt_d = '0;
                if (take) begin
                    char_d = char_if.charData;
                    if (char_if.charData == ASCII_SPACE) begin
                        state_d = WORD_GAP;
                        cnt_d   = WORD_M1;
                    end else if (code.ok) begin
                        state_d = MARK;
                        cnt_d   = code.pat[0] ? DASH_M1 : DOT_M1;
                    end
                end
            end
            MARK: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if ((idx_q + 3'd1) < code.len) begin
                    state_d = ELEM_GAP;
                    cnt_d   = DOT_M1;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    state_d = CHAR_GAP;
                    cnt_d   = DASH_M1;
                end
            end
            ELEM_GAP: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    state_d = MARK;
                    cnt_d   = code.pat[idx_q] ? DASH_M1 : DOT_M1;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Outputs follow the state being entered, so they stay registered.
        key_d   = (state_d == MARK);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) && !take;
    end

    // State and output registers; reset drops key at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            char_q  <= '0;
            key_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign char_if.charReady = ready_q;
    assign key               = key_q;
    assign busy              = busy_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer with a 4-clock dot unit.
// The reference model spells each character as a dot/dash string. It expands
// the string into a per-cycle list of expected {key, busy} values.
module tb_morse_keyer;

    localparam int U = 4;

    logic       clk;
    logic       reset;
    logic       key;
    logic       busy;
    logic [2:0] dbg_state;

    morse_keyer_if kif ();

    morse_keyer #(.unitCycles(U)) dut (
        .clk       (clk),
        .reset     (reset),
        .char_if   (kif),
        .key       (key),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // expected {key, busy} per cycle after a transfer; charReady is 0 throughout
    logic [1:0] exp_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: return "";
        endcase
    endfunction

    task automatic build_expect(input logic [7:0] c);
        string s;
        exp_q.delete();
        s = morse_of(c);
        if (c == 8'h20) begin
            repeat (4 * U) exp_q.push_back(2'b01);
        end else if (s.len() == 0) begin
            exp_q.push_back(2'b00);  // swallowed: ready low once, never busy
        end else begin
            for (int i = 0; i < s.len(); i++) begin
                repeat ((s[i] == "-") ? 3 * U : U) exp_q.push_back(2'b11);
                if (i < s.len() - 1) repeat (U) exp_q.push_back(2'b01);
                else                 repeat (3 * U) exp_q.push_back(2'b01);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; returns 1ns after the transfer edge.
    task automatic do_transfer(input logic [7:0] c, input bit keep_valid);
        int guard;
        guard = 0;
        kif.charData  = c;
        kif.charValid = 1'b1;
        while (kif.charReady !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("ready_wait", {31'd0, kif.charReady}, 32'd1);
        @(posedge clk);
        #1;
        kif.charData = 8'($urandom);  // keyer must keep its own copy
        if (!keep_valid) kif.charValid = 1'b0;
    endtask

    // Compare each following cycle against exp_q, then the one IDLE cycle.
    task automatic check_wave(input string name);
        logic [1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check_val({name, "_key"},  {31'd0, key},  {31'd0, e[1]});
            check_val({name, "_busy"}, {31'd0, busy}, {31'd0, e[0]});
            check_val({name, "_rdy"},  {31'd0, kif.charReady}, 32'd0);
        end
        @(negedge clk);
        check_val({name, "_idle_key"},  {31'd0, key},  32'd0);
        check_val({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check_val({name, "_idle_rdy"},  {31'd0, kif.charReady}, 32'd1);
    endtask

    task automatic send_char(input logic [7:0] c, input bit keep_valid, input string name);
        build_expect(c);
        do_transfer(c, keep_valid);
        check_wave(name);
    endtask

    task automatic idle_hold(input int n);
        repeat (n) begin
            @(negedge clk);
            check_val("hold_key",  {31'd0, key},  32'd0);
            check_val("hold_busy", {31'd0, busy}, 32'd0);
            check_val("hold_rdy",  {31'd0, kif.charReady}, 32'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] c;
        bit         keep;
        int         r;

        reset         = 1'b0;
        kif.charData  = 8'h00;
        kif.charValid = 1'b0;
        #12;
        check_val("rst_key",  {31'd0, key},  32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_rdy",  {31'd0, kif.charReady}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_first_edge_rdy", {31'd0, kif.charReady}, 32'd1);
        @(negedge clk);

        // directed cases
        send_char(8'h45, 1'b0, "E");
        idle_hold(10);
        send_char(8'h61, 1'b0, "a");
        send_char(8'h30, 1'b1, "zero");
        send_char(8'h20, 1'b0, "space");
        send_char(8'h23, 1'b0, "hash");
        idle_hold(3);

        // reset in the 6th cycle of the first dash of 'O'
        do_transfer(8'h4F, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check_val("o_dash_key", {31'd0, key}, 32'd1);
        reset = 1'b0;
        #1;
        check_val("async_rst_key",  {31'd0, key},  32'd0);
        check_val("async_rst_busy", {31'd0, busy}, 32'd0);
        check_val("async_rst_rdy",  {31'd0, kif.charReady}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rerelease_rdy", {31'd0, kif.charReady}, 32'd1);
        check_val("rerelease_key", {31'd0, key}, 32'd0);
        @(negedge clk);
        send_char(8'h54, 1'b0, "T");

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       c = 8'(8'h41 + $urandom_range(0, 25));
            else if (r < 6)  c = 8'(8'h61 + $urandom_range(0, 25));
            else if (r < 8)  c = 8'(8'h30 + $urandom_range(0, 9));
            else if (r == 8) c = 8'h20;
            else             c = 8'($urandom);
            keep = (n != 39) && ($urandom_range(0, 1) == 1);
            send_char(c, keep, "rand");
            if (!keep) idle_hold($urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
